// File: rtl/mask_pkg.sv
// Shared constants for the circular mask image generator: image geometry
// defaults and the RGB444 colours it produces.
package mask_pkg;

    localparam int IMG_W_DEFAULT  = 160;
    localparam int IMG_H_DEFAULT  = 120;
    localparam int RADIUS_DEFAULT = 40;

    localparam int COLOR_W = 12;

    localparam logic [COLOR_W-1:0] COL_BLACK  = 12'h000;
    localparam logic [COLOR_W-1:0] COL_WHITE  = 12'hFFF;
    localparam logic [COLOR_W-1:0] COL_BORDER = 12'hF00;

endpackage

// File: rtl/mask_pixel_gen.sv
// Combinational pixel colour for a circular mask with a one-pixel red frame;
// maps a (row, col) address to an RGB444 colour.
module mask_pixel_gen
    import mask_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEFAULT,
    parameter int IMG_H  = IMG_H_DEFAULT,
    parameter int RADIUS = RADIUS_DEFAULT
) (
    input  logic [6:0]         row,
    input  logic [7:0]         col,
    output logic [COLOR_W-1:0] color
);

    localparam int CX = IMG_W / 2;
    localparam int CY = IMG_H / 2;
    localparam logic [17:0] R2 = 18'(RADIUS * RADIUS);

    logic signed [8:0]  dx;
    logic signed [7:0]  dy;
    logic signed [17:0] dx_ext;
    logic signed [17:0] dy_ext;
    logic signed [17:0] dx_sq;
    logic signed [17:0] dy_sq;
    logic [17:0]        d2;
    logic               out_of_range;
    logic               on_border;

    // A zero-extended column cannot overflow 9 signed bits after centring,
    // and likewise the row in 8 bits, so the squares are always exact.
    assign dx     = $signed({1'b0, col}) - 9'(CX);
    assign dy     = $signed({1'b0, row}) - 8'(CY);
    assign dx_ext = 18'(dx);
    assign dy_ext = 18'(dy);
    assign dx_sq  = dx_ext * dx_ext;
    assign dy_sq  = dy_ext * dy_ext;
    assign d2     = $unsigned(dx_sq) + $unsigned(dy_sq);

    assign out_of_range = (32'(col) >= IMG_W) || (32'(row) >= IMG_H);
    assign on_border    = (row == '0) || (32'(row) == IMG_H - 1) ||
                          (col == '0) || (32'(col) == IMG_W - 1);

    always_comb begin
        color = COL_BLACK;
        if (out_of_range)
            color = COL_BLACK;
        else if (on_border)
            color = COL_BORDER;
        else if (d2 <= R2)
            color = COL_WHITE;
        else
            color = COL_BLACK;
    end

endmodule

// File: rtl/mask_rom.sv
// Read-only circular mask image: one address per cycle in, registered RGB444
// colour out one cycle later.
module mask_rom
    import mask_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEFAULT,
    parameter int IMG_H  = IMG_H_DEFAULT,
    parameter int RADIUS = RADIUS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         row,
    input  logic [7:0]         col,
    output logic [COLOR_W-1:0] color_data
);

    logic [COLOR_W-1:0] color_p0;
    logic [COLOR_W-1:0] color_p1;

    mask_pixel_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .RADIUS (RADIUS)
    ) u_pixel_gen (
        .row   (row),
        .col   (col),
        .color (color_p0)
    );

    // p0 -> p1: the only state in the block; reset forces black.
    always_ff @(posedge clk) begin
        if (rst)
            color_p1 <= COL_BLACK;
        else
            color_p1 <= color_p0;
    end

    assign color_data = color_p1;

endmodule

// File: tb/tb_mask_rom.sv
// Directed self-checking bench for mask_rom at default geometry.
module tb_mask_rom;

    logic        clk;
    logic        rst;
    logic [6:0]  row;
    logic [7:0]  col;
    logic [11:0] color_data;

    int n_checks;
    int n_fail;

    mask_rom dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .color_data (color_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: plain integer geometry at default size.
    function automatic logic [11:0] ref_color(input int r, input int c);
        int dxi, dyi;
        if (c >= 160 || r >= 120) return 12'h000;
        if (r == 0 || r == 119 || c == 0 || c == 159) return 12'hF00;
        dxi = c - 80;
        dyi = r - 60;
        if (dxi * dxi + dyi * dyi <= 1600) return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; row = 7'd21; col = 8'd88;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (color_data !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, color_data, 12'h000);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (color_data !== 12'hFFF) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", color_data, 12'hFFF);
        end
    endtask

    // Table of (row, col, expected) applied one per cycle.
    task automatic run_table(input string name, input int rows[], input int cols[],
                             input logic [11:0] exps[]);
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            row = 7'(rows[i]); col = 8'(cols[i]);
            @(posedge clk); #1;
            n_checks++;
            if (color_data !== exps[i]) begin
                n_fail++;
                $display("FAIL %s[%0d] (r=%0d c=%0d): got %h expected %h",
                         name, i, rows[i], cols[i], color_data, exps[i]);
            end
        end
    endtask

    task automatic test_circle_edge();
        run_table("circle_edge", '{21, 21, 21}, '{88, 89, 88},
                  '{12'hFFF, 12'h000, 12'hFFF});
    endtask

    task automatic test_exact_radius();
        run_table("exact_radius", '{60, 60, 60, 100, 20}, '{120, 121, 80, 80, 80},
                  '{12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF});
    endtask

    task automatic test_border();
        run_table("border", '{0, 0, 119, 37, 1, 60}, '{0, 159, 5, 0, 1, 159},
                  '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h000, 12'hF00});
    endtask

    task automatic test_out_of_range();
        run_table("out_of_range", '{60, 127, 120, 60}, '{160, 255, 80, 80},
                  '{12'h000, 12'h000, 12'h000, 12'hFFF});
    endtask

    task automatic test_hold();
        @(negedge clk);
        row = 7'd60; col = 8'd80;
        @(posedge clk); #1;
        n_checks++;
        if (color_data !== 12'hFFF) begin
            n_fail++;
            $display("FAIL hold_load: got %h expected %h", color_data, 12'hFFF);
        end
        #2 col = 8'd130;
        @(negedge clk);
        n_checks++;
        if (color_data !== 12'hFFF) begin
            n_fail++;
            $display("FAIL hold_between_edges: got %h expected %h", color_data, 12'hFFF);
        end
        @(posedge clk); #1;
        n_checks++;
        if (color_data !== 12'h000) begin
            n_fail++;
            $display("FAIL hold_next_edge: got %h expected %h", color_data, 12'h000);
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        row = 7'd60; col = 8'd80; rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (color_data !== 12'h000) begin
            n_fail++;
            $display("FAIL midstream_reset: got %h expected %h", color_data, 12'h000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (color_data !== 12'hFFF) begin
            n_fail++;
            $display("FAIL midstream_recover: got %h expected %h", color_data, 12'hFFF);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_cur;
        logic [11:0] exp_prev;
        exp_prev = color_data;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            n_checks++;
            if (color_data !== exp_prev) begin
                n_fail++;
                $display("FAIL b2b_pre_edge c=%0d: got %h expected %h", c, color_data, exp_prev);
            end
            row = 7'd60; col = 8'(c);
            exp_cur = ref_color(60, c);
            @(posedge clk); #1;
            n_checks++;
            if (color_data !== exp_cur) begin
                n_fail++;
                $display("FAIL b2b c=%0d: got %h expected %h", c, color_data, exp_cur);
            end
            exp_prev = exp_cur;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        row = '0;
        col = '0;
        test_reset();
        test_circle_edge();
        test_exact_radius();
        test_border();
        test_out_of_range();
        test_hold();
        test_midstream_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mask_rom.md
MASK_ROM -- requirements
Module: mask_rom

Interface
REQ-001 Parameter IMG_W, default 160, image width in pixels (valid col range 0..IMG_W-1).
REQ-002 Parameter IMG_H, default 120, image height in pixels (valid row range 0..IMG_H-1).
REQ-003 Parameter RADIUS, default 40, mask circle radius in pixels.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 row  input  7  pixel row address, unsigned.
REQ-007 col  input  8  pixel column address, unsigned.
REQ-008 color_data  output  12  RGB444 pixel colour {R[11:8],G[7:4],B[3:0]}, registered.

Function
REQ-009 Block SHALL be a read-only mask image generator; no write port, no stored RAM state other than the output register.
REQ-010 Circle centre SHALL be (CX,CY) = (IMG_W/2, IMG_H/2) = (80,60) at defaults.
REQ-011 dx = col - CX SHALL be computed as 9-bit signed; dy = row - CY as 8-bit signed; no overflow for any input value.
REQ-012 d2 = dx*dx + dy*dy SHALL be computed unsigned, at least 17 bits, compared against RADIUS*RADIUS (1600 at defaults).
REQ-013 Pixel colour SHALL be selected with this priority, highest first:
  (a) col >= IMG_W or row >= IMG_H -> 12'h000 (out of range);
  (b) row == 0, row == IMG_H-1, col == 0 or col == IMG_W-1 -> 12'hF00 (border);
  (c) d2 <= RADIUS*RADIUS -> 12'hFFF (mask open; boundary inclusive);
  (d) otherwise -> 12'h000 (background).
REQ-014 color_data SHALL reflect the row/col sampled at rising edge N, valid after edge N (latency 1 cycle); a new address is accepted every cycle.
REQ-015 Address changes between edges SHALL have no effect on color_data until the next rising edge.
REQ-016 Output SHALL be a pure function of the sampled address; identical addresses on consecutive cycles yield identical, stable data.

Reset
REQ-017 While rst is high at a rising edge, color_data SHALL load 12'h000 regardless of row/col.
REQ-018 First edge with rst low SHALL register the colour for the address present at that edge; no further recovery cycles.
REQ-019 Asserting rst mid-stream SHALL discard the pending lookup; no other state exists to clear.

Structure
REQ-020 Shared package mask_pkg SHALL hold IMG_W/IMG_H defaults, COLOR_W = 12, and colour constants COL_BLACK = 12'h000, COL_WHITE = 12'hFFF, COL_BORDER = 12'hF00.
REQ-021 One combinational sub-module mask_pixel_gen SHALL implement REQ-010..REQ-013 (row, col -> colour); mask_rom SHALL instantiate it and add only the reset/output register.

Verification
REQ-022 rst=1 for 2 cycles with row=21, col=88 -> color_data = 12'h000 throughout; after rst=0 and one edge -> 12'hFFF.
REQ-023 row=21 (0x15), col=88 (0x58): d2=1585 -> 12'hFFF one cycle later; row=21, col=89: d2=1602 -> 12'h000; back to col=88 -> 12'hFFF (inside/outside circle edge, inclusive compare).
REQ-024 row=60, col=120 (d2=1600 exactly) -> 12'hFFF; row=60, col=121 -> 12'h000; row=60, col=80 -> 12'hFFF.
REQ-025 Border: (0,0), (0,159), (119,5), (37,0) -> 12'hF00; (1,1) -> 12'h000.
REQ-026 Out of range: col=160, row=60 -> 12'h000; col=255, row=127 -> 12'h000.
REQ-027 Back-to-back sweep of col 0..159 on row 60, one address per cycle -> each output matches REQ-013 reference model, delayed exactly one cycle.
